note_pattern_sequencer: RTL and testbench

// Controller between the note recognizer and the graphics pattern generator.

---
 rtl/note_pattern_sequencer_if.sv | 30 +++
 rtl/note_pattern_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_note_pattern_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_pattern_sequencer_if.sv
// Bundle of the event and display signals around the note pattern sequencer.
//   note_vld    : 1-cycle strobe from the note recognizer
//   note_idx    : note index, 0..11 valid, 12..15 invalid
//   key_next    : manual advance key, already synchronous and debounced
//   pattern     : display pattern select (0..2 note classes, 3 default)
//   pattern_chg : 1-cycle pulse on every edge where pattern changes
//   sticky_note : last committed note, 4'hF when none
//   anim_tick   : 1-cycle enable for the animation counters
//   busy        : high while confirming a note or holding a committed one
// master drives the note/key side; slave is the sequencer itself.
interface note_pattern_sequencer_if;
    logic       note_vld;
    logic [3:0] note_idx;
    logic       key_next;
    logic [1:0] pattern;
    logic       pattern_chg;
    logic [3:0] sticky_note;
    logic       anim_tick;
    logic       busy;

    modport master (
        output note_vld, note_idx, key_next,
        input  pattern, pattern_chg, sticky_note, anim_tick, busy
    );

    modport slave (
        input  note_vld, note_idx, key_next,
        output pattern, pattern_chg, sticky_note, anim_tick, busy
    );
endinterface

// File: rtl/note_pattern_sequencer.sv
// Controller between the note recognizer and the graphics pattern generator.
// Qualifies note strobes by consecutive matches, commits a confirmed note as
// the sticky note and its pattern, holds it for a minimum dwell, and cycles
// patterns on its own when no music is heard. Also produces the animation tick.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : note_pattern_sequencer_if.slave (note/key inputs, display outputs)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no candidate; auto-advance every idle_ms, key_next advances
// S_CONFIRM | counting consecutive equal strobes; times out after idle_ms
// S_HOLD    | committed note shown; all inputs ignored for hold_ms
// (commit is the single edge CONFIRM/IDLE -> HOLD, not a state of its own)
module note_pattern_sequencer #(
    parameter int unsigned clk_mhz     = 50,
    parameter int unsigned confirm_cnt = 4,
    parameter int unsigned hold_ms     = 500,
    parameter int unsigned idle_ms     = 4000,
    parameter int unsigned w_tick      = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    note_pattern_sequencer_if.slave   bus
);

    localparam int unsigned PRE     = clk_mhz * 1000;
    localparam int unsigned PRE_W   = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int unsigned MAX_MS  = (idle_ms > hold_ms) ? idle_ms : hold_ms;
    localparam int unsigned TMR_W   = $clog2(MAX_MS + 1);
    localparam int unsigned MATCH_W = $clog2(confirm_cnt + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_HOLD
    } state_t;

    state_t               state, state_n;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 ms_tick;
    logic [TMR_W-1:0]     tmr;
    logic                 tmr_clr;
    logic                 exp_idle, exp_hold;
    logic [w_tick-1:0]    anim_cnt;
    logic                 anim_tick_q;
    logic                 key_q, key_rise;
    logic                 strobe_ok;
    logic [3:0]           cand, cand_n;
    logic [MATCH_W-1:0]   match, match_n, match_inc;
    logic [1:0]           pattern_q, pattern_n;
    logic                 chg_q;
    logic [3:0]           sticky_q, sticky_n;
    logic                 busy_q;

    function automatic logic [1:0] note_class(input logic [3:0] idx);
        return 2'(idx % 4'd3);
    endfunction

    // 3 -> 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] advance(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign ms_tick   = (pre_cnt == PRE_W'(PRE - 1));
    assign exp_idle  = (tmr == TMR_W'(idle_ms));
    assign exp_hold  = (tmr == TMR_W'(hold_ms));
    assign key_rise  = bus.key_next & ~key_q;
    assign strobe_ok = bus.note_vld && (bus.note_idx < 4'd12);
    assign match_inc = match + 1'b1;

    // Free-running prescaler; the FSM timer is cleared independently, so a
    // restart lands anywhere inside a ms period (+0/-1 ms accuracy).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anim_cnt    <= '0;
            anim_tick_q <= 1'b0;
        end else begin
            anim_cnt    <= anim_cnt + 1'b1;
            anim_tick_q <= &anim_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (tmr_clr) begin
            tmr <= '0;
        end else if (ms_tick) begin
            tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            key_q     <= 1'b0;
            cand      <= '0;
            match     <= '0;
            pattern_q <= 2'd3;
            chg_q     <= 1'b0;
            sticky_q  <= 4'hF;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            key_q     <= bus.key_next;
            cand      <= cand_n;
            match     <= match_n;
            pattern_q <= pattern_n;
            chg_q     <= (pattern_n != pattern_q);
            sticky_q  <= sticky_n;
            busy_q    <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        match_n   = match;
        pattern_n = pattern_q;
        sticky_n  = sticky_q;
        tmr_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe_ok) begin
                    tmr_clr = 1'b1;
                    if (confirm_cnt == 1) begin
                        sticky_n  = bus.note_idx;
                        pattern_n = note_class(bus.note_idx);
                        match_n   = '0;
                        state_n   = S_HOLD;
                    end else begin
                        cand_n  = bus.note_idx;
                        match_n = MATCH_W'(1);
                        state_n = S_CONFIRM;
                    end
                end else if (exp_idle || key_rise) begin
                    // both in one cycle still advance a single step
                    pattern_n = advance(pattern_q);
                    tmr_clr   = 1'b1;
                end
            end
            S_CONFIRM: begin
                // key wins over timeout and over a same-cycle commit
                if (key_rise) begin
                    pattern_n = advance(pattern_q);
                    match_n   = '0;
                    state_n   = S_IDLE;
                    tmr_clr   = 1'b1;
                end else if (exp_idle) begin
                    match_n = '0;
                    state_n = S_IDLE;
                    tmr_clr = 1'b1;
                end else if (strobe_ok) begin
                    if (bus.note_idx == cand) begin
                        if (match_inc == MATCH_W'(confirm_cnt)) begin
                            sticky_n  = cand;
                            pattern_n = note_class(cand);
                            match_n   = '0;
                            state_n   = S_HOLD;
                            tmr_clr   = 1'b1;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        // new candidate keeps the running timeout
                        cand_n  = bus.note_idx;
                        match_n = MATCH_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (exp_hold) begin
                    state_n = S_IDLE;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                tmr_clr = 1'b1;
            end
        endcase
    end

    assign bus.pattern     = pattern_q;
    assign bus.pattern_chg = chg_q;
    assign bus.sticky_note = sticky_q;
    assign bus.anim_tick   = anim_tick_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_note_pattern_sequencer.sv
// Self-checking bench for note_pattern_sequencer (clk_mhz=1, confirm_cnt=3,
// hold_ms=2, idle_ms=5, w_tick=4). A time-based model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_note_pattern_sequencer;

    localparam int PRE      = 1000;
    localparam int CONFIRM  = 3;
    localparam int HOLD_MS  = 2;
    localparam int IDLE_MS  = 5;
    localparam int TICK_PER = 16;

    localparam int M_IDLE    = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_HOLD    = 2;

    logic clk;
    logic rst;

    note_pattern_sequencer_if bus ();

    note_pattern_sequencer #(
        .clk_mhz     (1),
        .confirm_cnt (CONFIRM),
        .hold_ms     (HOLD_MS),
        .idle_ms     (IDLE_MS),
        .w_tick      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_n, m_st, m_pat, m_sticky, m_cand, m_match, m_entry;
    bit m_chg, m_anim, m_kprev;
    bit kr, sv, expd;
    int limit, old_pat;
    int adv_tbl [4] = '{1, 2, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, m_n, $time);
        end
    endtask

    // Absolute-time model: ms boundaries fall on edges that are multiples of
    // PRE; a state entered at edge e expires once limit boundaries after e
    // have passed, i.e. it acts on the edge following ((e/PRE)+limit)*PRE.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_st = M_IDLE; m_pat = 3; m_sticky = 15; m_chg = 0;
            m_anim = 0; m_cand = 0; m_match = 0; m_entry = 0; m_kprev = 0;
        end else begin
            m_n++;
            kr = bus.key_next && !m_kprev;
            m_kprev = bus.key_next;
            sv = bus.note_vld && (bus.note_idx < 12);
            limit = (m_st == M_HOLD) ? HOLD_MS : IDLE_MS;
            expd = (m_n - 1) >= ((m_entry / PRE) + limit) * PRE;
            old_pat = m_pat;
            case (m_st)
                M_IDLE: begin
                    if (sv) begin
                        m_cand = bus.note_idx; m_match = 1;
                        m_st = M_CONFIRM; m_entry = m_n;
                    end else if (expd || kr) begin
                        m_pat = adv_tbl[m_pat]; m_entry = m_n;
                    end
                end
                M_CONFIRM: begin
                    if (kr) begin
                        m_pat = adv_tbl[m_pat]; m_st = M_IDLE; m_entry = m_n;
                    end else if (expd) begin
                        m_st = M_IDLE; m_entry = m_n;
                    end else if (sv) begin
                        if (bus.note_idx == m_cand) m_match++;
                        else begin m_cand = bus.note_idx; m_match = 1; end
                        if (m_match == CONFIRM) begin
                            m_sticky = m_cand; m_pat = m_cand % 3;
                            m_st = M_HOLD; m_entry = m_n;
                        end
                    end
                end
                default: begin
                    if (expd) begin m_st = M_IDLE; m_entry = m_n; end
                end
            endcase
            m_chg = (m_pat != old_pat);
            m_anim = (m_n % TICK_PER) == 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pattern",     bus.pattern,     m_pat);
            chk("pattern_chg", bus.pattern_chg, m_chg);
            chk("sticky_note", bus.sticky_note, m_sticky);
            chk("anim_tick",   bus.anim_tick,   m_anim);
            chk("busy",        bus.busy,        m_st != M_IDLE);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic strobe(input int idx);
        bus.note_vld = 1'b1;
        bus.note_idx = 4'(idx);
        @(negedge clk);
        bus.note_vld = 1'b0;
    endtask

    task automatic until_edge(input int e);
        while (m_n < e) @(negedge clk);
    endtask

    task automatic reset_now(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_pattern"}, bus.pattern, 3);
        chk({tag, "_sticky"},  bus.sticky_note, 15);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_chg"},     bus.pattern_chg, 0);
        cyc(3);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.note_vld = 1'b0;
        bus.note_idx = 4'd0;
        bus.key_next = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_pattern", bus.pattern, 3);
        chk("rst_sticky",  bus.sticky_note, 15);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_anim",    bus.anim_tick, 0);
        cyc(3);
        rst = 1'b0;

        // free-running: anim tick and auto-advance
        until_edge(15);
        chk("anim_c15", bus.anim_tick, 0);
        @(negedge clk);
        chk("anim_c16", bus.anim_tick, 1);
        until_edge(5000);
        chk("auto_before", bus.pattern, 3);
        until_edge(5001);
        chk("auto1_pat", bus.pattern, 0);
        chk("auto1_chg", bus.pattern_chg, 1);
        until_edge(20001);
        chk("auto4_pat", bus.pattern, 0);
        chk("auto4_chg", bus.pattern_chg, 1);

        // three strobes of note 4 commit it
        strobe(4); strobe(4); strobe(4);
        chk("c4_sticky", bus.sticky_note, 4);
        chk("c4_pat",    bus.pattern, 1);
        chk("c4_chg",    bus.pattern_chg, 1);
        chk("c4_busy",   bus.busy, 1);
        cyc(1000);
        chk("c4_hold",   bus.busy, 1);
        cyc(1500);
        chk("c4_done",   bus.busy, 0);

        // candidate switch: 7,7,2,2,2
        strobe(7); strobe(7); strobe(2); strobe(2);
        chk("sw_no_commit", bus.sticky_note, 4);
        chk("sw_confirm",   bus.busy, 1);
        strobe(2);
        chk("sw_sticky", bus.sticky_note, 2);
        chk("sw_pat",    bus.pattern, 2);
        chk("sw_chg",    bus.pattern_chg, 1);

        // inputs ignored in HOLD
        repeat (5) strobe(13);
        strobe(5);
        bus.key_next = 1'b1;
        cyc(2);
        bus.key_next = 1'b0;
        cyc(1);
        chk("hold_sticky", bus.sticky_note, 2);
        chk("hold_pat",    bus.pattern, 2);
        chk("hold_busy",   bus.busy, 1);
        cyc(2000);
        chk("hold_exit",   bus.busy, 0);

        // invalid strobe in IDLE, then key beats the commit
        strobe(13);
        chk("inv_idle", bus.busy, 0);
        strobe(0); strobe(0);
        bus.key_next = 1'b1;
        strobe(0);
        chk("key_pat",    bus.pattern, 0);
        chk("key_chg",    bus.pattern_chg, 1);
        chk("key_sticky", bus.sticky_note, 2);
        chk("key_busy",   bus.busy, 0);
        bus.key_next = 1'b0;
        cyc(2);

        // async reset mid-HOLD
        strobe(4); strobe(4); strobe(4);
        chk("pre_rst_busy", bus.busy, 1);
        cyc(500);
        reset_now("rst_hold");

        // async reset mid-CONFIRM drops the pending match count
        strobe(1); strobe(1);
        cyc(3);
        reset_now("rst_conf");
        strobe(1);
        chk("no_pending_sticky", bus.sticky_note, 15);
        chk("no_pending_busy",   bus.busy, 1);
        chk("no_pending_pat",    bus.pattern, 3);

        // CONFIRM timeout returns to IDLE without changing pattern
        until_edge(5000);
        chk("to_before", bus.busy, 1);
        until_edge(5001);
        chk("to_busy", bus.busy, 0);
        chk("to_pat",  bus.pattern, 3);
        chk("to_chg",  bus.pattern_chg, 0);
        until_edge(10001);
        chk("to_adv_pat", bus.pattern, 0);
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
